// File: rtl/vec_pkg.sv
// Shared vector datapath types: ALU opcodes and the issue sequencer's states.
package vec_pkg;

    typedef enum logic [0:0] {
        eAdd = 1'b0,
        eSub = 1'b1
    } eOp;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eRun   = 2'd1,
        eDrain = 2'd2
    } eSeqState;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; clear together with up restarts at one.
module bsg_counter_clear_up #(
    parameter int max_val_p  = 8,
    parameter int init_val_p = 0,
    parameter int width_p    = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= width_p'(init_val_p);
        end else if (clear_i) begin
            count_o <= up_i ? width_p'(1) : '0;
        end else if (up_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

    // Counting past max_val_p means the caller lost track of the element count.
    count_no_overflow: assert property (
        @(posedge clk_i) disable iff (reset_i)
        (up_i && !clear_i) |-> (count_o != width_p'(max_val_p))
    );

endmodule

// File: rtl/vec_issue_seq.sv
// Element issue sequencer: walks elements 0..vlen-1 of one vector instruction,
// reads both sources from the RF and hands registered operand pairs to the ALU.
module vec_issue_seq
    import vec_pkg::*;
#(
    parameter int vdw_p      = 32,
    parameter int els_p      = 8,
    parameter int num_regs_p = 8,
    parameter int op_width_p = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic                          instr_v_i,
    output logic                          instr_ready_o,
    input  logic [op_width_p-1:0]         instr_op_i,
    input  logic [$clog2(num_regs_p)-1:0] instr_vd_i,
    input  logic [$clog2(num_regs_p)-1:0] instr_vs1_i,
    input  logic [$clog2(num_regs_p)-1:0] instr_vs2_i,
    input  logic [$clog2(els_p+1)-1:0]    instr_vlen_i,

    output logic [$clog2(num_regs_p)-1:0] rf_r_reg_a_o,
    output logic [$clog2(num_regs_p)-1:0] rf_r_reg_b_o,
    output logic [$clog2(els_p)-1:0]      rf_r_el_o,
    input  logic [vdw_p-1:0]              rf_r_data_a_i,
    input  logic [vdw_p-1:0]              rf_r_data_b_i,

    output logic                          ex_v_o,
    input  logic                          ex_ready_i,
    output logic [vdw_p-1:0]              ex_a_o,
    output logic [vdw_p-1:0]              ex_b_o,
    output logic [op_width_p-1:0]         ex_op_o,
    output logic [$clog2(num_regs_p)-1:0] ex_vd_o,
    output logic [$clog2(els_p)-1:0]      ex_el_o,
    output logic                          ex_last_o,

    output logic                          busy_o,
    output logic                          done_o
);

    localparam int el_w  = $clog2(els_p);
    localparam int len_w = $clog2(els_p + 1);
    localparam int reg_w = $clog2(num_regs_p);

    eSeqState state_r, state_n;

    logic [op_width_p-1:0] op_r;
    logic [reg_w-1:0]      vd_r, vs1_r, vs2_r;
    logic [len_w-1:0]      vlen_r;
    logic [len_w-1:0]      count;

    logic accept, load, ex_clear, done_n, last_el;

    bsg_counter_clear_up #(
        .max_val_p (els_p),
        .init_val_p(0),
        .width_p   (len_w)
    ) el_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(accept),
        .up_i   (load),
        .count_o(count)
    );

    // Full-width compare so vlen == els_p finishes at els_p-1 without wrapping.
    assign last_el = (count == vlen_r - len_w'(1));

    assign instr_ready_o = (state_r == eIdle);
    assign busy_o        = (state_r != eIdle);
    assign rf_r_reg_a_o  = vs1_r;
    assign rf_r_reg_b_o  = vs2_r;
    assign rf_r_el_o     = count[el_w-1:0];

    always_comb begin
        state_n  = state_r;
        accept   = 1'b0;
        load     = 1'b0;
        ex_clear = 1'b0;
        done_n   = 1'b0;
        case (state_r)
            eIdle: begin
                if (instr_v_i) begin
                    accept = 1'b1;
                    if (instr_vlen_i == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = eRun;
                    end
                end
            end
            eRun: begin
                if (!ex_v_o || ex_ready_i) begin
                    load = 1'b1;
                    if (last_el) begin
                        state_n = eDrain;
                    end
                end
            end
            eDrain: begin
                if (ex_v_o && ex_ready_i) begin
                    ex_clear = 1'b1;
                    done_n   = 1'b1;
                    state_n  = eIdle;
                end
            end
            default: state_n = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIdle;
            done_o  <= 1'b0;
            op_r    <= '0;
            vd_r    <= '0;
            vs1_r   <= '0;
            vs2_r   <= '0;
            vlen_r  <= '0;
        end else begin
            state_r <= state_n;
            done_o  <= done_n;
            if (accept) begin
                op_r   <= instr_op_i;
                vd_r   <= instr_vd_i;
                vs1_r  <= instr_vs1_i;
                vs2_r  <= instr_vs2_i;
                vlen_r <= instr_vlen_i;
            end
        end
    end

    // Output register only moves on a load, so a stalled pair stays put.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_v_o    <= 1'b0;
            ex_a_o    <= '0;
            ex_b_o    <= '0;
            ex_op_o   <= '0;
            ex_vd_o   <= '0;
            ex_el_o   <= '0;
            ex_last_o <= 1'b0;
        end else if (load) begin
            ex_v_o    <= 1'b1;
            ex_a_o    <= rf_r_data_a_i;
            ex_b_o    <= rf_r_data_b_i;
            ex_op_o   <= op_r;
            ex_vd_o   <= vd_r;
            ex_el_o   <= count[el_w-1:0];
            ex_last_o <= last_el;
        end else if (ex_clear) begin
            ex_v_o <= 1'b0;
        end
    end

    vlen_legal: assert property (
        @(posedge clk_i) disable iff (reset_i)
        accept |-> (instr_vlen_i <= len_w'(els_p))
    );

endmodule

// File: tb/tb_vec_issue_seq.sv
// Scoreboard bench for vec_issue_seq: expected pairs and done cycles are queued
// at issue time and retired by a negedge monitor.
module tb_vec_issue_seq;
    import vec_pkg::*;

    localparam int vdw_p = 32;
    localparam int els_p = 8;
    localparam int num_regs_p = 8;
    localparam int op_width_p = 1;
    localparam int el_w = $clog2(els_p);
    localparam int len_w = $clog2(els_p + 1);
    localparam int reg_w = $clog2(num_regs_p);

    typedef struct {
        logic [vdw_p-1:0] a;
        logic [vdw_p-1:0] b;
        logic [op_width_p-1:0] op;
        logic [reg_w-1:0] vd;
        logic [el_w-1:0] el;
        logic last;
        int cyc;
    } exp_pair_t;

    logic clk = 1'b0;
    logic reset_i;
    logic instr_v_i;
    logic instr_ready_o;
    logic [op_width_p-1:0] instr_op_i;
    logic [reg_w-1:0] instr_vd_i, instr_vs1_i, instr_vs2_i;
    logic [len_w-1:0] instr_vlen_i;
    logic [reg_w-1:0] rf_r_reg_a_o, rf_r_reg_b_o;
    logic [el_w-1:0] rf_r_el_o;
    logic [vdw_p-1:0] rf_r_data_a_i, rf_r_data_b_i;
    logic ex_v_o, ex_ready_i;
    logic [vdw_p-1:0] ex_a_o, ex_b_o;
    logic [op_width_p-1:0] ex_op_o;
    logic [reg_w-1:0] ex_vd_o;
    logic [el_w-1:0] ex_el_o;
    logic ex_last_o, busy_o, done_o;

    logic [vdw_p-1:0] rf [num_regs_p][els_p];
    exp_pair_t sb[$];
    int done_q[$];
    int cyc = 0;
    int test_count = 0;
    int fail_count = 0;

    vec_issue_seq #(
        .vdw_p(vdw_p), .els_p(els_p), .num_regs_p(num_regs_p), .op_width_p(op_width_p)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .instr_v_i(instr_v_i), .instr_ready_o(instr_ready_o),
        .instr_op_i(instr_op_i), .instr_vd_i(instr_vd_i),
        .instr_vs1_i(instr_vs1_i), .instr_vs2_i(instr_vs2_i), .instr_vlen_i(instr_vlen_i),
        .rf_r_reg_a_o(rf_r_reg_a_o), .rf_r_reg_b_o(rf_r_reg_b_o), .rf_r_el_o(rf_r_el_o),
        .rf_r_data_a_i(rf_r_data_a_i), .rf_r_data_b_i(rf_r_data_b_i),
        .ex_v_o(ex_v_o), .ex_ready_i(ex_ready_i),
        .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_op_o(ex_op_o),
        .ex_vd_o(ex_vd_o), .ex_el_o(ex_el_o), .ex_last_o(ex_last_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rf_r_data_a_i = rf[rf_r_reg_a_o][rf_r_el_o];
    assign rf_r_data_b_i = rf[rf_r_reg_b_o][rf_r_el_o];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Retire handshakes and done pulses against the queued expectations.
    always @(negedge clk) begin
        exp_pair_t e;
        if (reset_i === 1'b0) begin
            if (ex_v_o && ex_ready_i) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pair", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ex_a", ex_a_o, e.a);
                    checkOutput("ex_b", ex_b_o, e.b);
                    checkOutput("ex_op", ex_op_o, e.op);
                    checkOutput("ex_vd", ex_vd_o, e.vd);
                    checkOutput("ex_el", ex_el_o, e.el);
                    checkOutput("ex_last", ex_last_o, e.last);
                    checkOutput("hs_cycle", cyc, e.cyc);
                end
            end else if (ex_v_o && !ex_ready_i && sb.size() > 0) begin
                checkOutput("stall_a", ex_a_o, sb[0].a);
                checkOutput("stall_el", ex_el_o, sb[0].el);
            end
            if (done_o) begin
                if (done_q.size() == 0) checkOutput("unexpected_done", 1, 0);
                else checkOutput("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [op_width_p-1:0] op, input logic [reg_w-1:0] vd,
                                 input logic [reg_w-1:0] vs1, input logic [reg_w-1:0] vs2,
                                 input int vlen, input int stall_el, input int stall_len,
                                 output int acc);
        int waited = 0;
        exp_pair_t e;
        @(negedge clk);
        while (!instr_ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready_o) begin
            checkOutput("accept_timeout", 0, 1);
            acc = -1;
            return;
        end
        instr_v_i = 1'b1;
        instr_op_i = op;
        instr_vd_i = vd;
        instr_vs1_i = vs1;
        instr_vs2_i = vs2;
        instr_vlen_i = len_w'(vlen);
        @(posedge clk);
        #1;
        acc = cyc;
        instr_v_i = 1'b0;
        for (int i = 0; i < vlen; i++) begin
            e.a = rf[vs1][i];
            e.b = rf[vs2][i];
            e.op = op;
            e.vd = vd;
            e.el = el_w'(i);
            e.last = (i == vlen - 1);
            e.cyc = acc + 1 + i + ((i >= stall_el) ? stall_len : 0);
            sb.push_back(e);
        end
        done_q.push_back((vlen == 0) ? acc : acc + vlen + 1 + stall_len);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || done_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_left", sb.size() + done_q.size(), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, instr_ready_o, 1);
        checkOutput({tag, "_ex_v"}, ex_v_o, 0);
        checkOutput({tag, "_last"}, ex_last_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_a"}, ex_a_o, 0);
        checkOutput({tag, "_b"}, ex_b_o, 0);
        checkOutput({tag, "_el"}, ex_el_o, 0);
        checkOutput({tag, "_vd"}, ex_vd_o, 0);
        checkOutput({tag, "_op"}, ex_op_o, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, acc2;
        for (int r = 0; r < num_regs_p; r++)
            for (int i = 0; i < els_p; i++)
                rf[r][i] = $urandom;
        for (int i = 0; i < els_p; i++) begin
            rf[1][i] = i;
            rf[2][i] = 10 * i;
        end
        reset_i = 1'b1;
        instr_v_i = 1'b0;
        instr_op_i = '0;
        instr_vd_i = '0;
        instr_vs1_i = '0;
        instr_vs2_i = '0;
        instr_vlen_i = '0;
        ex_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 reset_i = 1'b0;

        // Full-length add, ALU always ready.
        applyStimulus(eAdd, 3'd3, 3'd1, 3'd2, 8, 99, 0, acc);
        waitDrain();

        // Two-cycle backpressure while element 1 is presented.
        applyStimulus(eAdd, 3'd4, 3'd1, 3'd2, 3, 1, 2, acc);
        @(posedge clk);
        @(posedge clk);
        #1 ex_ready_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 ex_ready_i = 1'b1;
        waitDrain();

        // Zero-length instruction completes without issuing.
        applyStimulus(eSub, 3'd2, 3'd1, 3'd2, 0, 99, 0, acc);
        @(negedge clk);
        checkOutput("vlen0_ready", instr_ready_o, 1);
        checkOutput("vlen0_ex_v", ex_v_o, 0);
        waitDrain();

        // Back-to-back: second accepted in the first one's done cycle.
        applyStimulus(eSub, 3'd5, 3'd3, 3'd4, 2, 99, 0, acc);
        applyStimulus(eAdd, 3'd6, 3'd6, 3'd7, 1, 99, 0, acc2);
        checkOutput("b2b_accept", acc2, acc + 4);
        waitDrain();

        // Reset while element 4 of 8 is presented abandons the instruction.
        applyStimulus(eAdd, 3'd1, 3'd1, 3'd2, 8, 99, 0, acc);
        repeat (5) @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        done_q.delete();
        @(negedge clk);
        checkResetValues("midreset");
        @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_reset_busy", busy_o, 0);
        applyStimulus(eSub, 3'd7, 3'd5, 3'd0, 1, 99, 0, acc);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
